// File: rtl/slave_memory.sv
// Bus slave around a 256 x 32-bit memory with byte/halfword/word access; sub-word writes use read-modify-write.
// Optional: define SLAVE_MEM_SIGN_EXT_EN to sign-extend byte and halfword reads.
module slave_memory (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic [31:0] Addr,
    input  logic [8:0]  Control,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  current_addr;
    logic [1:0]  current_size;
    logic        wr_flag;
    logic [31:0] wr_buf;
    logic [31:0] rd_word;
    logic [31:0] mem [0:255];

    logic        cap_en, rd_en, mem_we, ready_nxt, dout_ld;
    logic [31:0] merged, rd_data;
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic unused_bits;
    assign unused_bits = ^{Addr[31:10], Control[8:3]};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (En) state_nxt = ACCESS;
            ACCESS:   state_nxt = En ? COMPLETE : IDLE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_en    = (state == IDLE) && En;
        rd_en     = (state == ACCESS) && En;
        mem_we    = (state == COMPLETE) && wr_flag;
        ready_nxt = (state == COMPLETE);
        dout_ld   = (state == COMPLETE) && !wr_flag;
    end

    // Lane steering for both the write merge and the read extract
    always_comb begin
        lane     = current_addr[1:0];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = current_addr[1] ? rd_word[31:16] : rd_word[15:0];
        merged   = rd_word;
        rd_data  = rd_word;
        case (current_size)
            2'b00: begin
                merged[{lane, 3'b000} +: 8] = wr_buf[7:0];
`ifdef SLAVE_MEM_SIGN_EXT_EN
                rd_data = {{24{byte_sel[7]}}, byte_sel};
`else
                rd_data = {24'h0, byte_sel};
`endif
            end
            2'b01: begin
                if (current_addr[1]) merged[31:16] = wr_buf[15:0];
                else                 merged[15:0]  = wr_buf[15:0];
`ifdef SLAVE_MEM_SIGN_EXT_EN
                rd_data = {{16{half_sel[15]}}, half_sel};
`else
                rd_data = {16'h0, half_sel};
`endif
            end
            default: begin
                merged  = wr_buf;
                rd_data = rd_word;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            current_addr <= '0;
            current_size <= '0;
            wr_flag      <= 1'b0;
            wr_buf       <= '0;
        end else if (cap_en) begin
            current_addr <= Addr[9:0];
            current_size <= Control[2:1];
            wr_flag      <= Control[0];
            wr_buf       <= DataIn;
        end
    end

    // Storage is never reset; mem_we is already forced low by the reset state
    always_ff @(posedge Clk) begin
        if (mem_we) mem[current_addr[9:2]] <= merged;
        if (rd_en)  rd_word <= mem[current_addr[9:2]];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Ready   <= 1'b0;
            DataOut <= '0;
        end else begin
            Ready <= ready_nxt;
            if (dout_ld) DataOut <= rd_data;
        end
    end

endmodule

// File: tb/tb_slave_memory.sv
// Scoreboarded bench for slave_memory: expected read data from a byte-array model, checked on each Ready.
module tb_slave_memory;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        En = 1'b0;
    logic [31:0] Addr = '0;
    logic [8:0]  Control = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        Ready;

    slave_memory dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Addr(Addr), .Control(Control),
        .DataIn(DataIn), .DataOut(DataOut), .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t       sb[$];
    int         pass_cnt = 0;
    int         tot_cnt = 0;
    bit         rdy_prev = 1'b0;
    logic [7:0] model [1024];

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [8:0] c);
        logic [9:0] b;
        logic [31:0] v;
        b = a[9:0];
        if (c[2]) begin
            b = {b[9:2], 2'b00};
            v = {model[b + 3], model[b + 2], model[b + 1], model[b]};
        end else if (c[1]) begin
            b = {b[9:1], 1'b0};
`ifdef SLAVE_MEM_SIGN_EXT_EN
            v = {{16{model[b + 1][7]}}, model[b + 1], model[b]};
`else
            v = {16'h0, model[b + 1], model[b]};
`endif
        end else begin
`ifdef SLAVE_MEM_SIGN_EXT_EN
            v = {{24{model[b][7]}}, model[b]};
`else
            v = {24'h0, model[b]};
`endif
        end
        return v;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [8:0] c, input logic [31:0] d);
        logic [9:0] b;
        int n;
        b = a[9:0];
        if (c[2])      begin b = {b[9:2], 2'b00}; n = 4; end
        else if (c[1]) begin b = {b[9:1], 1'b0};  n = 2; end
        else           n = 1;
        for (int i = 0; i < n; i++) model[b + 10'(i)] = d[i*8 +: 8];
    endfunction

    // Monitor: every Ready pops one expectation and must be a single-cycle pulse
    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (Ready) begin
            tot_cnt++;
            if (rdy_prev) $display("FAIL ready_width: Ready high two cycles, required one");
            else pass_cnt++;
            if (sb.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_ready: Ready=1 with no request pending, required 0");
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    tot_cnt++;
                    if (DataOut !== e.data)
                        $display("FAIL %s: DataOut=%h required %h", e.name, DataOut, e.data);
                    else pass_cnt++;
                end
            end
        end
        rdy_prev = Ready;
    end

    task automatic drive(input logic [31:0] a, input logic [8:0] c, input logic [31:0] d,
                         input bit chk, input string nm, output int lat);
        exp_t e;
        @(negedge Clk);
        En = 1'b1; Addr = a; Control = c; DataIn = d;
        e.chk = chk && !c[0];
        e.data = c[0] ? 32'h0 : model_read(a, c);
        e.name = nm;
        if (c[0]) model_write(a, c, d);
        sb.push_back(e);
        @(posedge Clk);
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!Ready && lat < 10);
        En = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int lat;
        Rst = 1'b0; En = 1'b1; Control = 9'h000; Addr = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        tot_cnt++;
        if (Ready !== 1'b0) $display("FAIL reset_ready: Ready=%b required 0", Ready); else pass_cnt++;
        tot_cnt++;
        if (DataOut !== 32'h0) $display("FAIL reset_dataout: DataOut=%h required 0", DataOut); else pass_cnt++;
        @(negedge Clk);
        Rst = 1'b1;
        e.chk = 1'b0; e.data = '0; e.name = "reset_first";
        sb.push_back(e);
        @(posedge Clk);
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!Ready && lat < 10);
        En = 1'b0;
        tot_cnt++;
        if (lat != 2) $display("FAIL reset_first_latency: Ready %0d edges after accept, required 2", lat);
        else pass_cnt++;
    endtask

    task automatic test_word();
        int lat;
        drive(32'h078, 9'h007, 32'hDEADBEEF, 1'b1, "word_wr", lat);
        tot_cnt++;
        if (lat != 2) $display("FAIL word_wr_latency: %0d required 2", lat); else pass_cnt++;
        drive(32'h078, 9'h004, 32'h0, 1'b1, "word_rd", lat);
        tot_cnt++;
        if (DataOut !== 32'hDEADBEEF) $display("FAIL word_rd_value: DataOut=%h required deadbeef", DataOut);
        else pass_cnt++;
    endtask

    task automatic test_half();
        int lat;
        drive(32'h07C, 9'h007, 32'h0000ABCD, 1'b1, "half_setup", lat);
        drive(32'h07C, 9'h002, 32'h0, 1'b1, "half_rd_lo", lat);
        tot_cnt++;
        if (DataOut !== 32'h0000ABCD) $display("FAIL half_rd_lo_value: DataOut=%h required 0000abcd", DataOut);
        else pass_cnt++;
        drive(32'h07E, 9'h002, 32'h0, 1'b1, "half_rd_hi", lat);
    endtask

    task automatic test_rmw();
        int lat;
        drive(32'h34C, 9'h007, 32'h0, 1'b1, "rmw_clear", lat);
        drive(32'h34E, 9'h003, 32'hB7462120, 1'b1, "rmw_half_wr", lat);
        drive(32'h34C, 9'h004, 32'h0, 1'b1, "rmw_word_rd", lat);
        tot_cnt++;
        if (DataOut !== 32'h21200000) $display("FAIL rmw_word_value: DataOut=%h required 21200000", DataOut);
        else pass_cnt++;
        drive(32'h34F, 9'h000, 32'h0, 1'b1, "rmw_byte_rd", lat);
    endtask

    task automatic test_byte();
        int lat;
        drive(32'h3F4, 9'h007, 32'h11223344, 1'b1, "byte_setup", lat);
        drive(32'h3F6, 9'h001, 32'h000002EB, 1'b1, "byte_wr", lat);
        drive(32'h3F6, 9'h000, 32'h0, 1'b1, "byte_rd", lat);
        tot_cnt++;
`ifdef SLAVE_MEM_SIGN_EXT_EN
        if (DataOut !== 32'hFFFFFFEB) $display("FAIL byte_rd_value: DataOut=%h required ffffffeb", DataOut);
`else
        if (DataOut !== 32'h000000EB) $display("FAIL byte_rd_value: DataOut=%h required 000000eb", DataOut);
`endif
        else pass_cnt++;
        drive(32'h3F4, 9'h004, 32'h0, 1'b1, "byte_lanes", lat);
        tot_cnt++;
        if (DataOut !== 32'h11EB3344) $display("FAIL byte_lanes_value: DataOut=%h required 11eb3344", DataOut);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        @(negedge Clk);
        En = 1'b1; Addr = 32'h078; Control = 9'h007; DataIn = 32'h12345678;
        @(posedge Clk);
        @(negedge Clk);
        En = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge Clk);
            #1;
            if (Ready) seen++;
        end
        tot_cnt++;
        if (seen != 0) $display("FAIL abort_no_ready: %0d Ready pulses required 0", seen); else pass_cnt++;
        drive(32'h078, 9'h004, 32'h0, 1'b1, "abort_mem", lat);
        tot_cnt++;
        if (DataOut !== 32'hDEADBEEF) $display("FAIL abort_mem_value: DataOut=%h required deadbeef", DataOut);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge Clk);
        En = 1'b1; Addr = 32'h078; Control = 9'h007; DataIn = 32'h55555555;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        tot_cnt++;
        if (Ready !== 1'b0) $display("FAIL rstmid_ready: Ready=%b required 0", Ready); else pass_cnt++;
        tot_cnt++;
        if (DataOut !== 32'h0) $display("FAIL rstmid_dataout: DataOut=%h required 0", DataOut); else pass_cnt++;
        En = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        drive(32'h078, 9'h004, 32'h0, 1'b1, "rstmid_discard", lat);
        tot_cnt++;
        if (lat != 2) $display("FAIL rstmid_latency: %0d required 2", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        @(negedge Clk);
        En = 1'b1; Addr = 32'h07C; Control = 9'h004; DataIn = '0;
        e.chk = 1'b1; e.data = model_read(32'h07C, 9'h004); e.name = "b2b_first";
        sb.push_back(e);
        @(posedge Clk);
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!Ready && lat < 10);
        Addr = 32'h34C;
        e.chk = 1'b1; e.data = model_read(32'h34C, 9'h004); e.name = "b2b_second";
        sb.push_back(e);
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!Ready && lat < 10);
        En = 1'b0;
        tot_cnt++;
        if (lat != 3) $display("FAIL b2b_spacing: %0d edges between Ready pulses required 3", lat);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_half();
        test_rmw();
        test_byte();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(posedge Clk);
        #2;
        tot_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
